// File: rtl/tdm_demux1to4_sync.sv
// rtl/tdm_demux1to4_sync.sv - 1:4 TDM receive demux with frame-sync lock (optional TDM_DEMUX_ERR_EN)
// TDM_DEMUX_ERR_EN adds sync_err_cnt, a saturating count of LOCKED->HUNT drops.
module tdm_demux1to4_sync #(
    parameter int WIDTH    = 8,
    parameter int LOCK_CNT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic [3:0]       y_valid,
    output logic             frame_done,
    output logic             locked,
`ifdef TDM_DEMUX_ERR_EN
    output logic [7:0]       sync_err_cnt,
`endif
    output logic [1:0]       slot
);

    localparam int CW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);

    localparam logic [1:0] HUNT   = 2'd0;
    localparam logic [1:0] VERIFY = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] good_cnt;
    logic [CW:0]   cnt_inc;
    logic          lock_now;
    logic          mismatch;

    // A sync marker is expected exactly on slot 0; anything else breaks the frame.
    always_comb begin
        cnt_inc  = {1'b0, good_cnt} + {{CW{1'b0}}, 1'b1};
        lock_now = (cnt_inc == (CW + 1)'(LOCK_CNT));
        mismatch = frame_sync != (slot == 2'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y0         <= '0;
            y1         <= '0;
            y2         <= '0;
            y3         <= '0;
            y_valid    <= '0;
            frame_done <= 1'b0;
            locked     <= 1'b0;
            slot       <= 2'd0;
            state      <= HUNT;
            good_cnt   <= '0;
`ifdef TDM_DEMUX_ERR_EN
            sync_err_cnt <= 8'd0;
`endif
        end else begin
            y_valid    <= '0;
            frame_done <= 1'b0;
            if (din_valid) begin
                case (state)
                    HUNT: begin
                        if (frame_sync) begin
                            good_cnt <= CW'(1);
                            slot     <= 2'd1;
                            if (LOCK_CNT == 1) begin
                                state   <= LOCKED;
                                locked  <= 1'b1;
                                y0      <= din;
                                y_valid <= 4'b0001;
                            end else begin
                                state <= VERIFY;
                            end
                        end
                    end
                    VERIFY: begin
                        if (mismatch) begin
                            state    <= HUNT;
                            good_cnt <= '0;
                            slot     <= 2'd0;
                        end else begin
                            slot <= slot + 2'd1;
                            if (slot == 2'd0) begin
                                good_cnt <= cnt_inc[CW-1:0];
                                // The sync word that completes the lock is delivered as slot 0.
                                if (lock_now) begin
                                    state   <= LOCKED;
                                    locked  <= 1'b1;
                                    y0      <= din;
                                    y_valid <= 4'b0001;
                                end
                            end
                        end
                    end
                    LOCKED: begin
                        if (mismatch) begin
                            state    <= HUNT;
                            locked   <= 1'b0;
                            good_cnt <= '0;
                            slot     <= 2'd0;
`ifdef TDM_DEMUX_ERR_EN
                            if (sync_err_cnt != 8'hFF)
                                sync_err_cnt <= sync_err_cnt + 8'd1;
`endif
                        end else begin
                            case (slot)
                                2'd0:    y0 <= din;
                                2'd1:    y1 <= din;
                                2'd2:    y2 <= din;
                                default: y3 <= din;
                            endcase
                            y_valid    <= 4'b0001 << slot;
                            frame_done <= (slot == 2'd3);
                            slot       <= slot + 2'd1;
                        end
                    end
                    default: begin
                        state    <= HUNT;
                        locked   <= 1'b0;
                        good_cnt <= '0;
                        slot     <= 2'd0;
                    end
                endcase
            end
        end
    end

endmodule
